lut_cfg_loader: RTL

Programmable 2^ADDR_W x 1 lookup table with a serial configuration write port. It is the writer side of the team's combinational LUT read interface (addr -> data).
- A controller streams the truth table in one bit per valid/ready beat into a shadow register.
- The shadow is committed atomically to the active table only after the last bit is accepted.
- The read port therefore never sees a partially loaded table.

---
 rtl/lut_pkg.sv | 17 +
 rtl/lut_core.sv | 32 +++
 rtl/lut_cfg_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/lut_pkg.sv
// Shared types and helpers for the serially configured lookup table.
// The loader FSM states and the table depth calculation live here.
package lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } lut_cfg_state_e;

  localparam int LUT_ADDR_W_DEF = 3;

  function automatic int lut_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/lut_core.sv
// Active lookup table: holds the committed truth table and serves the
// combinational addr -> data read port.
module lut_core
  import lut_pkg::*;
#(
  parameter int                            ADDR_W     = LUT_ADDR_W_DEF,
  parameter logic [lut_depth(ADDR_W)-1:0]  INIT_TABLE = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            commit,
  input  logic [lut_depth(ADDR_W)-1:0]    load_data,
  input  logic [ADDR_W-1:0]               addr,
  output logic                            data
);

  localparam int DEPTH = lut_depth(ADDR_W);

  logic [DEPTH-1:0] active_r;

  // Active table register, replaced as a whole on a commit strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r <= INIT_TABLE;
    end else if (commit) begin
      active_r <= load_data;
    end
  end

  assign data = active_r[addr];

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial configuration writer for lut_core: bits are collected into a
// shadow register and committed atomically once the full table is received.
module lut_cfg_loader
  import lut_pkg::*;
#(
  parameter int                            ADDR_W     = LUT_ADDR_W_DEF,
  parameter logic [lut_depth(ADDR_W)-1:0]  INIT_TABLE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_ready,
  output logic               cfg_done,
  output logic               busy,
  input  logic [ADDR_W-1:0]  addr,
  output logic               data
);

  localparam int                DEPTH    = lut_depth(ADDR_W);
  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);

  lut_cfg_state_e    state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DEPTH-1:0]  shadow_r;
  logic              cfg_ready_r;
  logic              cfg_done_r;
  logic              busy_r;
  logic              commit_s;

  // Load-session FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      shadow_r    <= '0;
      cfg_ready_r <= 1'b0;
      cfg_done_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cfg_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_start) begin
            state_r     <= LOAD;
            cnt_r       <= '0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        LOAD: begin
          // abort takes priority over a beat offered in the same cycle
          if (cfg_abort) begin
            state_r     <= IDLE;
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b0;
          end else if (cfg_valid && cfg_ready_r) begin
            shadow_r[cnt_r[ADDR_W-1:0]] <= cfg_bit;
            cnt_r                       <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_IDX) begin
              state_r     <= COMMIT;
              cfg_ready_r <= 1'b0;
            end
          end
        end
        COMMIT: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          cfg_done_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          cfg_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign commit_s  = (state_r == COMMIT);
  assign cfg_ready = cfg_ready_r;
  assign cfg_done  = cfg_done_r;
  assign busy      = busy_r;

  lut_core #(
    .ADDR_W     (ADDR_W),
    .INIT_TABLE (INIT_TABLE)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .commit    (commit_s),
    .load_data (shadow_r),
    .addr      (addr),
    .data      (data)
  );

endmodule
